// File: rtl/bs_drain_pkg.sv
// Shared types and entry-layout helpers for the bank drain controller and its array neighbours.
package bs_drain_pkg;

  typedef enum logic {
    RD_MODE = 1'b0,
    WR_MODE = 1'b1
  } mode_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int ARR_NUM_RD_DEF = 4;
  localparam int ARR_NUM_WR_DEF = 3;
  localparam int RA_BITS_DEF    = 4;
  localparam int INDEX_BITS_DEF = 7;
  localparam int DATA_BITS_DEF  = 16;

  // Read heads are {index,row}; write heads and the output are {index,data,row}.
  function automatic int rd_entry_bits(input int index_bits, input int ra_bits);
    return index_bits + ra_bits;
  endfunction

  function automatic int wr_entry_bits(input int index_bits, input int data_bits, input int ra_bits);
    return index_bits + data_bits + ra_bits;
  endfunction

endpackage

// File: rtl/bank_drain_ctrl_rr_pick.sv
// One-hot round-robin picker: first requester strictly after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] pos_s;
  logic          hit_s;

  // Scan offsets 1..N so the array at ptr itself is considered last.
  always_comb begin
    gnt   = {N{1'b0}};
    idx   = {PW{1'b0}};
    any   = 1'b0;
    pos_s = {PW{1'b0}};
    hit_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos_s      = PW'((int'(ptr) + k) % N);
      hit_s      = req[pos_s] & ~any;
      gnt[pos_s] = gnt[pos_s] | hit_s;
      idx        = hit_s ? pos_s : idx;
      any        = any | hit_s;
    end
  end

endmodule

// File: rtl/bank_drain_ctrl.sv
// Drain side of the bank scheduler: read-first, watermark write drain, per-type round robin.
// Optional row-hit bursting is enabled with `define BURST_ROW_HIT_EN.
module bank_drain_ctrl
  import bs_drain_pkg::*;
#(
  parameter int ARR_NUM_RD = ARR_NUM_RD_DEF,
  parameter int ARR_NUM_WR = ARR_NUM_WR_DEF,
  parameter int RA_BITS    = RA_BITS_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
`ifdef BURST_ROW_HIT_EN
  ,
  parameter int MAX_BURST  = 4
`endif
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [ARR_NUM_RD-1:0]                                  rd_valid,
  input  logic [ARR_NUM_RD*(INDEX_BITS+RA_BITS)-1:0]             rd_data,
  input  logic [ARR_NUM_WR-1:0]                                  wr_valid,
  input  logic [ARR_NUM_WR*(INDEX_BITS+DATA_BITS+RA_BITS)-1:0]   wr_data,
  input  logic                                                   hwm,
  input  logic                                                   lwm,
  output logic [ARR_NUM_RD-1:0]                                  rd_pop,
  output logic [ARR_NUM_WR-1:0]                                  wr_pop,
  input  logic                                                   grant_i,
  output logic                                                   valid_o,
  output logic                                                   type_o,
  output logic [INDEX_BITS+DATA_BITS+RA_BITS-1:0]                data_o
);

  localparam int RD_W = rd_entry_bits(INDEX_BITS, RA_BITS);
  localparam int WR_W = wr_entry_bits(INDEX_BITS, DATA_BITS, RA_BITS);
  localparam int RPW  = $clog2(ARR_NUM_RD);
  localparam int WPW  = $clog2(ARR_NUM_WR);

  mode_e                  mode_r, mode_nx_s;
  logic                   load_s, burst_s, pop_any_s;
  logic                   valid_r, type_r;
  logic [WR_W-1:0]        data_r;
  logic [RPW-1:0]         rd_ptr_r, rd_idx_s, rd_sel_idx_s;
  logic [WPW-1:0]         wr_ptr_r, wr_idx_s, wr_sel_idx_s;
  logic [ARR_NUM_RD-1:0]  rd_gnt_s, rd_pop_s;
  logic [ARR_NUM_WR-1:0]  wr_gnt_s, wr_pop_s;
  logic                   rd_any_s, wr_any_s;
  logic [RD_W-1:0]        rd_slot_s;
  logic [WR_W-1:0]        rd_entry_s, wr_entry_s;

  // Pops are suppressed while reset is held so the arrays never lose a head during reset.
  assign load_s = rst_n & (~valid_r | grant_i);

  rr_pick #(.N(ARR_NUM_RD), .PW(RPW)) u_rd_pick (
    .req (rd_valid),
    .ptr (rd_ptr_r),
    .gnt (rd_gnt_s),
    .idx (rd_idx_s),
    .any (rd_any_s)
  );

  rr_pick #(.N(ARR_NUM_WR), .PW(WPW)) u_wr_pick (
    .req (wr_valid),
    .ptr (wr_ptr_r),
    .gnt (wr_gnt_s),
    .idx (wr_idx_s),
    .any (wr_any_s)
  );

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= RD_MODE;
    end else begin
      mode_r <= mode_nx_s;
    end
  end

  // Mode next state, evaluated only in load slots.
  always_comb begin
    mode_nx_s = mode_r;
    if (load_s) begin
      case (mode_r)
        RD_MODE: mode_nx_s = (hwm || (!rd_any_s && wr_any_s)) ? WR_MODE : RD_MODE;
        WR_MODE: mode_nx_s = ((lwm && !hwm) || !wr_any_s) ? RD_MODE : WR_MODE;
        default: mode_nx_s = RD_MODE;
      endcase
    end else begin
      mode_nx_s = mode_r;
    end
  end

`ifdef BURST_ROW_HIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt_r;
  logic          rd_hit_s, wr_hit_s;

  assign rd_hit_s = rd_valid[rd_ptr_r] &&
                    (rd_data[int'(rd_ptr_r)*RD_W +: RA_BITS] == data_r[RA_BITS-1:0]);
  assign wr_hit_s = wr_valid[wr_ptr_r] &&
                    (wr_data[int'(wr_ptr_r)*WR_W +: RA_BITS] == data_r[RA_BITS-1:0]);
  // A non-zero count means the previous load slot popped this mode's pointer array.
  assign burst_s  = (burst_cnt_r != {CW{1'b0}}) && (burst_cnt_r < CW'(MAX_BURST)) &&
                    (mode_nx_s == mode_r) && ((mode_r == RD_MODE) ? rd_hit_s : wr_hit_s);

  // Burst length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r <= {CW{1'b0}};
    end else if (load_s) begin
      if (!pop_any_s) begin
        burst_cnt_r <= {CW{1'b0}};
      end else if (burst_s) begin
        burst_cnt_r <= burst_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        burst_cnt_r <= {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  assign burst_s = 1'b0;
`endif

  // Pop selection for the mode chosen in this slot.
  always_comb begin
    rd_pop_s     = {ARR_NUM_RD{1'b0}};
    wr_pop_s     = {ARR_NUM_WR{1'b0}};
    rd_sel_idx_s = burst_s ? rd_ptr_r : rd_idx_s;
    wr_sel_idx_s = burst_s ? wr_ptr_r : wr_idx_s;
    if (load_s && (mode_nx_s == RD_MODE)) begin
      rd_pop_s = burst_s ? ({{(ARR_NUM_RD-1){1'b0}}, 1'b1} << rd_ptr_r) : rd_gnt_s;
    end else if (load_s && (mode_nx_s == WR_MODE)) begin
      wr_pop_s = burst_s ? ({{(ARR_NUM_WR-1){1'b0}}, 1'b1} << wr_ptr_r) : wr_gnt_s;
    end else begin
      rd_pop_s = {ARR_NUM_RD{1'b0}};
      wr_pop_s = {ARR_NUM_WR{1'b0}};
    end
  end

  assign pop_any_s  = (|rd_pop_s) | (|wr_pop_s);
  assign rd_slot_s  = rd_data[int'(rd_sel_idx_s)*RD_W +: RD_W];
  assign rd_entry_s = {rd_slot_s[RD_W-1:RA_BITS], {DATA_BITS{1'b0}}, rd_slot_s[RA_BITS-1:0]};
  assign wr_entry_s = wr_data[int'(wr_sel_idx_s)*WR_W +: WR_W];

  // Output request register and round-robin pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= 1'b0;
      type_r   <= READ;
      data_r   <= {WR_W{1'b0}};
      rd_ptr_r <= RPW'(ARR_NUM_RD - 1);
      wr_ptr_r <= WPW'(ARR_NUM_WR - 1);
    end else if (load_s) begin
      valid_r <= pop_any_s;
      if (|rd_pop_s) begin
        type_r   <= READ;
        data_r   <= rd_entry_s;
        rd_ptr_r <= rd_sel_idx_s;
      end else if (|wr_pop_s) begin
        type_r   <= WRITE;
        data_r   <= wr_entry_s;
        wr_ptr_r <= wr_sel_idx_s;
      end
    end
  end

  assign rd_pop  = rd_pop_s;
  assign wr_pop  = wr_pop_s;
  assign valid_o = valid_r;
  assign type_o  = type_r;
  assign data_o  = data_r;

endmodule

// File: tb/tb_bank_drain_ctrl.sv
// Self-checking bench for bank_drain_ctrl: queue-based array model plus directed and random steps.
module tb_bank_drain_ctrl;

  localparam int NR = 4;
  localparam int NW = 3;
  localparam int RW = 11;
  localparam int EW = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]    rd_valid = '0;
  logic [NR*RW-1:0] rd_data = '0;
  logic [NW-1:0]    wr_valid = '0;
  logic [NW*EW-1:0] wr_data = '0;
  logic hwm = 1'b0, lwm = 1'b0, grant_i = 1'b0;
  logic [NR-1:0] rd_pop;
  logic [NW-1:0] wr_pop;
  logic valid_o, type_o;
  logic [EW-1:0] data_o;

  always #5 clk = ~clk;

  bank_drain_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_data(wr_data), .hwm(hwm), .lwm(lwm),
    .rd_pop(rd_pop), .wr_pop(wr_pop), .grant_i(grant_i),
    .valid_o(valid_o), .type_o(type_o), .data_o(data_o)
  );

  // Array contents: entries stored as {index,data,row}; reads carry data=0.
  logic [EW-1:0] rq [NR][$];
  logic [EW-1:0] wq [NW][$];
  int obs_q[$];
  int vectors = 0;
  int miscompares = 0;
  int tag_ctr = 0;

  bit m_valid, m_type, m_mode;
  logic [EW-1:0] m_data;
  int m_rptr, m_wptr, m_bcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_order(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) chk(tag, obs_q[i], exp_q[i]);
    end
  endtask

  function automatic int qsize(input bit w, input int g);
    return w ? wq[g].size() : rq[g].size();
  endfunction

  function automatic logic [EW-1:0] qhead(input bit w, input int g);
    return w ? wq[g][0] : rq[g][0];
  endfunction

  task automatic push_rd(input int g, input int row);
    tag_ctr++;
    rq[g].push_back({7'(tag_ctr), 16'h0000, 4'(row)});
  endtask

  task automatic push_wr(input int g, input int row);
    tag_ctr++;
    wq[g].push_back({7'(tag_ctr), 16'($urandom), 4'(row)});
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_type = 1'b0; m_mode = 1'b0; m_data = '0;
    m_rptr = NR - 1; m_wptr = NW - 1; m_bcnt = 0;
  endtask

  task automatic drive_arrays();
    logic [EW-1:0] e;
    for (int g = 0; g < NR; g++) begin
      rd_valid[g] = rq[g].size() > 0;
      e = (rq[g].size() > 0) ? rq[g][0] : '0;
      rd_data[g*RW +: RW] = {e[26:20], e[3:0]};
    end
    for (int g = 0; g < NW; g++) begin
      wr_valid[g] = wq[g].size() > 0;
      wr_data[g*EW +: EW] = (wq[g].size() > 0) ? wq[g][0] : '0;
    end
  endtask

  // One clock of the reference model: predict, compare at negedge, commit at posedge.
  task automatic step();
    bit load, nmode, anyr, anyw, burst;
    int pick, ptr, n;
    logic [NR-1:0] erd;
    logic [NW-1:0] ewr;
    drive_arrays();
    anyr = 0; anyw = 0;
    for (int g = 0; g < NR; g++) if (rq[g].size() > 0) anyr = 1;
    for (int g = 0; g < NW; g++) if (wq[g].size() > 0) anyw = 1;
    load = !m_valid || grant_i;
    nmode = m_mode;
    if (load) begin
      if (!m_mode) nmode = hwm || (!anyr && anyw);
      else nmode = !((lwm && !hwm) || !anyw);
    end
    pick = -1; burst = 0;
    ptr = nmode ? m_wptr : m_rptr;
    n = nmode ? NW : NR;
    if (load) begin
`ifdef BURST_ROW_HIT_EN
      if (m_bcnt > 0 && m_bcnt < 4 && nmode == m_mode && qsize(nmode, ptr) > 0 &&
          qhead(nmode, ptr)[3:0] == m_data[3:0]) begin
        pick = ptr; burst = 1;
      end
`endif
      for (int off = 1; off <= n; off++)
        if (pick < 0 && qsize(nmode, (ptr + off) % n) > 0) pick = (ptr + off) % n;
    end
    erd = '0; ewr = '0;
    if (pick >= 0 && !nmode) erd[pick] = 1'b1;
    if (pick >= 0 && nmode) ewr[pick] = 1'b1;
    @(negedge clk);
    chk("rd_pop", rd_pop, erd);
    chk("wr_pop", wr_pop, ewr);
    chk("valid_o", valid_o, m_valid);
    if (m_valid) begin
      chk("type_o", type_o, m_type);
      chk("data_o", data_o, m_data);
    end
    for (int g = 0; g < NR; g++) if (rd_pop[g]) obs_q.push_back(g);
    for (int g = 0; g < NW; g++) if (wr_pop[g]) obs_q.push_back(8 + g);
    @(posedge clk);
    if (load) begin
      m_mode = nmode;
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_type = nmode;
        if (nmode) begin m_data = wq[pick].pop_front(); m_wptr = pick; end
        else begin m_data = rq[pick].pop_front(); m_rptr = pick; end
        m_bcnt = burst ? m_bcnt + 1 : 1;
      end else begin
        m_valid = 1'b0;
        m_bcnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_pops", {rd_pop, wr_pop}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int e[$];
    int wcnt;
    model_reset();
    drive_arrays();
    #3;
    chk("reset_valid", valid_o, 0);
    chk("reset_type", type_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_pops", {rd_pop, wr_pop}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: two reads each in arrays 0 and 2, continuous grant.
    push_rd(0, 1); push_rd(0, 2); push_rd(2, 3); push_rd(2, 4);
    grant_i = 1'b1;
    obs_q.delete();
    repeat (4) step();
    chk("t1_valid_run", valid_o, 1);
    e = {0, 2, 0, 2};
    chk_order("t1_order", e);
    step();
    chk("t1_drop", valid_o, 0);

    // T2: high watermark forces a write drain ahead of pending reads.
    push_rd(1, 5); push_rd(3, 6);
    push_wr(0, 7); push_wr(0, 8); push_wr(0, 9);
    obs_q.delete();
    hwm = 1'b1;
    repeat (2) step();
    hwm = 1'b0; lwm = 1'b1;
    repeat (2) step();
    lwm = 1'b0;
    repeat (2) step();
    e = {8, 8, 3, 1, 8};
    chk_order("t2_order", e);

    // T3: arbiter backpressure holds the output and blocks pops.
    push_rd(0, 1); push_rd(2, 2); push_rd(2, 3);
    step();
    grant_i = 1'b0;
    obs_q.delete();
    repeat (3) begin
      step();
      chk("t3_hold", data_o, m_data);
    end
    chk("t3_no_pops", obs_q.size(), 0);
    grant_i = 1'b1;

    // T4: drain to empty; valid drops one cycle after the last accept.
    repeat (3) step();
    chk("t4_idle", valid_o, 0);
    chk("t4_no_pops", {rd_pop, wr_pop}, 0);

    // T5: row-hit candidates in array 1 against a single entry in array 2.
    do_reset();
    push_rd(1, 5); push_rd(1, 5); push_rd(1, 5); push_rd(2, 9);
    obs_q.delete();
    repeat (5) step();
`ifdef BURST_ROW_HIT_EN
    e = {1, 1, 1, 2};
`else
    e = {1, 2, 1, 1};
`endif
    chk_order("t5_order", e);

    // T6: asynchronous reset while a request is held; restart from array 0.
    for (int g = 0; g < 3; g++) begin push_rd(g, g); push_rd(g, g + 4); end
    repeat (2) step();
    chk("t6_pre_valid", valid_o, 1);
    #2;
    do_reset();
    obs_q.delete();
    step();
    chk_order("t6_restart", '{0});
    repeat (8) step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) push_rd($urandom_range(0, NR - 1), ($urandom_range(0, 1) != 0) ? 5 : $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) push_wr($urandom_range(0, NW - 1), ($urandom_range(0, 1) != 0) ? 5 : $urandom_range(0, 15));
      wcnt = 0;
      for (int g = 0; g < NW; g++) wcnt += wq[g].size();
      grant_i = ($urandom_range(0, 3) != 0);
      hwm = (wcnt >= 6) || ($urandom_range(0, 15) == 0);
      lwm = (wcnt <= 2);
      step();
    end
    grant_i = 1'b1; hwm = 1'b0; lwm = 1'b1;
    repeat (60) step();
    chk("final_idle", valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
